// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the core has priority, DMA gets idle cycles, and a
// starved DMA requester gets a bounded forced burst while the pipeline is stalled.
module dmem_port_arbiter #(
   parameter int unsigned MAX_WAIT  = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        core_re,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        dma_forced
);

   localparam int unsigned WaitW  = $clog2(MAX_WAIT + 1);
   localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
   localparam logic [WaitW-1:0]  WaitLast  = WaitW'(MAX_WAIT - 1);
   localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

   typedef enum logic {StCore, StForce} state_e;

   state_e             r_state;
   logic [WaitW-1:0]   r_wait_cnt;
   logic [BurstW-1:0]  r_burst_cnt;

   logic w_core_act;
   logic w_in_force;
   logic w_own_core;
   logic w_own_dma;

   assign w_core_act = core_re | core_we;
   assign w_in_force = (r_state == StForce);

   // Reset gates ownership so every memory-facing output is quiet while Reset is low.
   assign w_own_core = Reset & ~w_in_force & w_core_act;
   assign w_own_dma  = Reset & dma_req & (w_in_force | ~w_core_act);

   always_comb begin
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      if (w_own_core) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_re    = core_re;
         mem_we    = core_we;
      end else if (w_own_dma) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_re    = ~dma_we;
         mem_we    = dma_we;
      end
   end

   assign core_stall = Reset & w_in_force;
   assign dma_forced = Reset & w_in_force;
   assign dma_ack    = w_own_dma;
   assign core_rdata = mem_rdata;
   assign dma_rdata  = mem_rdata;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= StCore;
         r_wait_cnt  <= '0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            StCore: begin
               if (dma_req && w_core_act) begin
                  r_wait_cnt <= r_wait_cnt + WaitW'(1);
                  if (r_wait_cnt == WaitLast) begin
                     r_state     <= StForce;
                     r_burst_cnt <= '0;
                  end
               end else begin
                  r_wait_cnt <= '0;
               end
            end
            StForce: begin
               if (dma_req && (r_burst_cnt != BurstLast)) begin
                  r_burst_cnt <= r_burst_cnt + BurstW'(1);
               end else begin
                  // Burst complete or requester went away: hand the port back.
                  r_state     <= StCore;
                  r_wait_cnt  <= '0;
                  r_burst_cnt <= '0;
               end
            end
            default: begin
               r_state     <= StCore;
               r_wait_cnt  <= '0;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

   localparam int MW = 4;
   localparam int MB = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        core_re, core_we, dma_req, dma_we;
   logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
   logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        core_stall, dma_ack, mem_re, mem_we, dma_forced;

   logic [31:0] mem [0:255];
   int          wr80 = 0;
   int          errors = 0;
   int          checks = 0;

   dmem_port_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
      .Clk(Clk), .Reset(Reset),
      .core_re(core_re), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .dma_forced(dma_forced)
   );

   always #5 Clk = ~Clk;

   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge Clk) begin
      if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         if (mem_addr == 32'h80) wr80 <= wr80 + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: starvation count and words granted in the current forced burst.
   bit m_forced = 0;
   int m_starve = 0;
   int m_burst  = 0;

   always @(negedge Clk) begin
      logic        e_stall, e_ack, e_re, e_we;
      logic [31:0] e_addr, e_wdata, e_rd;
      bit          act, own_core, own_dma;
      act = core_re | core_we;
      own_core = 0; own_dma = 0;
      if (!Reset) begin
         m_forced = 0; m_starve = 0; m_burst = 0;
      end else begin
         own_dma  = dma_req && (m_forced || !act);
         own_core = !m_forced && act;
      end
      e_stall = Reset && m_forced;
      e_ack   = own_dma;
      e_re    = own_core ? core_re : (own_dma ? !dma_we : 1'b0);
      e_we    = own_core ? core_we : (own_dma ? dma_we : 1'b0);
      e_addr  = own_core ? core_addr : (own_dma ? dma_addr : 32'h0);
      e_wdata = own_core ? core_wdata : (own_dma ? dma_wdata : 32'h0);
      e_rd    = mem[e_addr[9:2]];
      chk("m_stall", {31'h0, core_stall}, {31'h0, e_stall});
      chk("m_forced", {31'h0, dma_forced}, {31'h0, e_stall});
      chk("m_ack", {31'h0, dma_ack}, {31'h0, e_ack});
      chk("m_re", {31'h0, mem_re}, {31'h0, e_re});
      chk("m_we", {31'h0, mem_we}, {31'h0, e_we});
      chk("m_addr", mem_addr, e_addr);
      chk("m_wdata", mem_wdata, e_wdata);
      if (own_core && core_re) chk("m_core_rdata", core_rdata, e_rd);
      if (own_dma && !dma_we)  chk("m_dma_rdata", dma_rdata, e_rd);
      if (Reset) begin
         if (m_forced) begin
            if (dma_req) m_burst++;
            if (!dma_req || m_burst == MB) begin
               m_forced = 0; m_starve = 0; m_burst = 0;
            end
         end else if (dma_req && act) begin
            m_starve++;
            if (m_starve == MW) begin
               m_forced = 1; m_burst = 0;
            end
         end else begin
            m_starve = 0;
         end
      end
   end

   task automatic drv(input logic re, input logic we, input logic [31:0] ca,
                      input logic [31:0] cw, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dd);
      core_re = re; core_we = we; core_addr = ca; core_wdata = cw;
      dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dd;
   endtask

   task automatic to_neg();
      @(negedge Clk);
   endtask

   task automatic to_pos();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      to_pos();
   endtask

   initial begin
      int iters;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      Reset = 1'b1;
      drv(1, 1, 32'h40, 32'h55, 1, 1, 32'h44, 32'h66);
      #1 Reset = 1'b0;

      // Reset with everything requesting: port must be quiet.
      to_neg();
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_re", {31'h0, mem_re}, 32'h0);
      chk("rst_ack", {31'h0, dma_ack}, 32'h0);
      chk("rst_stall", {31'h0, core_stall}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      to_pos();
      Reset = 1'b1;
      drv(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
      to_neg();
      chk("t1_re", {31'h0, mem_re}, 32'h1);
      chk("t1_addr", mem_addr, 32'h20);
      chk("t1_stall", {31'h0, core_stall}, 32'h0);
      to_pos();

      // Opportunistic DMA write, then core read-back.
      drv(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
      to_neg();
      chk("t2_ack", {31'h0, dma_ack}, 32'h1);
      chk("t2_we", {31'h0, mem_we}, 32'h1);
      to_pos();
      drv(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
      to_neg();
      chk("t2_rdata", core_rdata, 32'hDEADBEEF);
      to_pos();

      // Starvation then a full forced burst.
      for (int i = 1; i <= 9; i++) begin
         drv(1, 0, 32'h10, 32'h0, (i < 9), 0, 32'h40, 32'h0);
         to_neg();
         chk($sformatf("t3_ack%0d", i), {31'h0, dma_ack}, {31'h0, (i >= 5 && i <= 8)});
         chk($sformatf("t3_stall%0d", i), {31'h0, core_stall}, {31'h0, (i >= 5 && i <= 8)});
         if (i >= 5 && i <= 8) chk("t3_dma_rdata", dma_rdata, 32'hDEADBEEF);
         to_pos();
      end
      idle();

      // Forced grant abandoned after two words.
      for (int i = 1; i <= 8; i++) begin
         drv(1, 0, 32'h10, 32'h0, (i <= 6), 0, 32'h40, 32'h0);
         to_neg();
         chk($sformatf("t4_ack%0d", i), {31'h0, dma_ack}, {31'h0, (i == 5 || i == 6)});
         chk($sformatf("t4_stall%0d", i), {31'h0, core_stall}, {31'h0, (i >= 5 && i <= 7)});
         if (i == 7) chk("t4_noacc", {30'h0, mem_re, mem_we}, 32'h0);
         if (i == 8) chk("t4_core_re", {31'h0, mem_re}, 32'h1);
         to_pos();
      end
      idle();

      // Core write held while stalled completes exactly once.
      for (int i = 1; i <= 4; i++) begin
         drv(1, 0, 32'h10, 32'h0, 1, 1, 32'h100, 32'hA5);
         to_neg();
         to_pos();
      end
      iters = 0;
      for (int k = 0; k < 10; k++) begin
         logic s;
         drv(0, 1, 32'h80, 32'h11, 1, 1, 32'h100, 32'hA5);
         to_neg();
         s = core_stall;
         to_pos();
         iters++;
         if (!s) break;
      end
      chk("t5_iters", iters, 32'd5);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      chk("t5_wrcount", wr80, 32'd1);
      chk("t5_mem", mem[32], 32'h11);
      to_pos();
      idle();

      // Asynchronous reset in the middle of a forced burst.
      for (int i = 1; i <= 6; i++) begin
         drv(1, 0, 32'h10, 32'h0, 1, 1, 32'h104, 32'h77);
         to_neg();
         to_pos();
      end
      #2;
      chk("t6_pre_stall", {31'h0, core_stall}, 32'h1);
      Reset = 1'b0;
      #1;
      chk("t6_we", {31'h0, mem_we}, 32'h0);
      chk("t6_ack", {31'h0, dma_ack}, 32'h0);
      chk("t6_stall", {31'h0, core_stall}, 32'h0);
      chk("t6_forced", {31'h0, dma_forced}, 32'h0);
      chk("t6_addr", mem_addr, 32'h0);
      to_neg();
      to_pos();
      Reset = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      chk("t6_post_stall", {31'h0, core_stall}, 32'h0);
      chk("t6_post_forced", {31'h0, dma_forced}, 32'h0);
      to_pos();
      drv(0, 0, 0, 0, 1, 0, 32'h104, 32'h0);
      to_neg();
      chk("t6_reack", {31'h0, dma_ack}, 32'h1);
      to_pos();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
